// File: rtl/reg_pipe.sv
// reg_pipe: elastic register pipeline with valid/ready backpressure.
//
// Holds up to DEPTH items of WIDTH bits. Each stage tracks its own valid bit.
// Empty stages fill while later stages stall. An occupancy count is provided.
//
// Parameters:
//   WIDTH     - data width in bits (>= 1)
//   DEPTH     - number of register stages (>= 1)
//   RESET_VAL - value loaded into every data register on reset and on clear
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   reset     - asynchronous active-low reset
//   en        - global enable; 0 freezes every stage
//   sclr      - synchronous clear (exists only when REG_PIPE_SCLR_EN is defined)
//   in_valid  - upstream has data
//   in_data   - upstream data
//   in_ready  - item is accepted this cycle (combinational)
//   out_valid - last stage holds data
//   out_data  - last-stage data
//   out_ready - downstream accepts out_data this cycle
//   count     - number of valid stages
//
// Optional feature macro: REG_PIPE_SCLR_EN adds the sclr port and clear logic.

module reg_pipe #(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       DEPTH     = 2,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
`ifdef REG_PIPE_SCLR_EN
   input  logic                          sclr,
`endif
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          out_ready,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]  r_valid;
   logic [WIDTH-1:0]  r_data [DEPTH];
   logic [CNT_W-1:0]  r_count;

   logic [DEPTH-1:0]  w_acc;
   logic [DEPTH-1:0]  w_src_valid;
   logic [WIDTH-1:0]  w_src_data [DEPTH];
   logic              w_sclr;
   logic              w_in_xfer;
   logic              w_out_xfer;

`ifdef REG_PIPE_SCLR_EN
   assign w_sclr = sclr;
`else
   assign w_sclr = 1'b0;
`endif

   // Ready chain, walked from the output stage back to the input stage.
   // A stage can load when it is empty or its item moves on this cycle.
   always_comb begin
      logic v_acc;
      w_acc = '0;
      v_acc = out_ready;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         v_acc    = en & (~r_valid[k] | v_acc);
         w_acc[k] = v_acc;
      end
   end

   // Source of each stage: upstream port for stage 0, previous stage otherwise.
   always_comb begin
      w_src_valid    = '0;
      w_src_data[0]  = in_data;
      w_src_valid[0] = in_valid;
      for (int k = 1; k < int'(DEPTH); k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_data[k]  = r_data[k-1];
      end
   end

   // Reset gating keeps in_ready low while reset is held.
   assign in_ready   = w_acc[0] & reset & ~w_sclr;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = r_valid[DEPTH-1] & out_ready & en & ~w_sclr;

   // Stage registers; data only changes when a valid item is written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int k = 0; k < int'(DEPTH); k++) r_data[k] <= RESET_VAL;
      end else if (w_sclr) begin
         r_valid <= '0;
         for (int k = 0; k < int'(DEPTH); k++) r_data[k] <= RESET_VAL;
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (w_acc[k]) begin
               r_valid[k] <= w_src_valid[k];
               if (w_src_valid[k]) r_data[k] <= w_src_data[k];
            end
         end
      end
   end

   // Occupancy: simultaneous in and out leave the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (w_sclr) begin
         r_count <= '0;
      end else begin
         case ({w_in_xfer, w_out_xfer})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign count     = r_count;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed testbench for reg_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
module tb_reg_pipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam logic [7:0]  RV    = 8'hA5;

   logic             clk;
   logic             reset;
   logic             en;
   logic             sclr;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;

   int total;
   int bad;

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
`ifdef REG_PIPE_SCLR_EN
      .sclr      (sclr),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [WIDTH+CW:0] got;
      reset = 1'b0; en = 1'b1; sclr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         out_ready = 1'($urandom_range(0, 1));
         step();
         got = {out_valid, out_data, count};
         total++;
         if (got !== {1'b0, RV, CW'(0)}) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got v=%0b d=%h c=%0d want v=0 d=a5 c=0", i, out_valid, out_data, count);
         end
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready[%0d]: got %0b want 0", i, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      reset = 1'b1;
      step();
      total++;
      if ({out_valid, count, in_ready} !== {1'b0, CW'(0), 1'b1}) begin
         bad++;
         $display("FAIL reset_release: got v=%0b c=%0d rdy=%0b want v=0 c=0 rdy=1", out_valid, count, in_ready);
      end
   endtask

   task automatic test_stream();
      logic [WIDTH+CW:0] got;
      logic [WIDTH+CW:0] exp;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i + 1);
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready);
         end
         step();
         if (i >= 2) exp = {1'b1, 8'(i - 1), CW'(3)};
         else        exp = {1'b0, RV, CW'(i + 1)};
         got = {out_valid, out_data, count};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL stream[%0d]: got {v,d,c}=%h want %h", i, got, exp);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i < 2) exp = {1'b1, 8'(7 + i), CW'(2 - i)};
         else       exp = {1'b0, 8'd8, CW'(0)};
         got = {out_valid, out_data, count};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL stream_drain[%0d]: got {v,d,c}=%h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH+CW:0] got;
      logic [WIDTH+CW:0] exp;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(10 + i);
         step();
      end
      in_valid = 1'b1;
      in_data  = 8'd13;
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b1, 8'd10, CW'(3)}) begin
         bad++;
         $display("FAIL bp_full: got {v,d,c}=%h want %h", got, {1'b1, 8'd10, CW'(3)});
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_full_in_ready: got %0b want 0", in_ready);
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_full_ready_out: got %0b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) exp = {1'b1, 8'(11 + i), CW'(3 - i)};
         else       exp = {1'b0, 8'd13, CW'(0)};
         got = {out_valid, out_data, count};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL bp_order[%0d]: got {v,d,c}=%h want %h", i, got, exp);
         end
         step();
      end
   endtask

   task automatic test_bubble();
      logic [WIDTH+CW:0] got;
      logic [WIDTH+CW:0] exp;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'd7;
      step();
      in_valid = 1'b0;
      step();
      step();
      in_valid = 1'b1; in_data = 8'd8;
      step();
      in_valid = 1'b0;
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b1, 8'd7, CW'(2)}) begin
         bad++;
         $display("FAIL bubble_held: got {v,d,c}=%h want %h", got, {1'b1, 8'd7, CW'(2)});
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bubble_in_ready: got %0b want 1", in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         case (i)
            0:       exp = {1'b0, 8'd7, CW'(1)};
            1:       exp = {1'b1, 8'd8, CW'(1)};
            default: exp = {1'b0, 8'd8, CW'(0)};
         endcase
         got = {out_valid, out_data, count};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL bubble_drain[%0d]: got {v,d,c}=%h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_enable();
      logic [WIDTH+CW:0] got;
      logic [WIDTH+CW:0] exp;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(20 + i);
         step();
      end
      out_ready = 1'b1;
      en = 1'b0;
      in_valid = 1'b1; in_data = 8'd23;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL en_in_ready[%0d]: got %0b want 0", i, in_ready);
         end
         step();
         got = {out_valid, out_data, count};
         total++;
         if (got !== {1'b1, 8'd20, CW'(3)}) begin
            bad++;
            $display("FAIL en_frozen[%0d]: got {v,d,c}=%h want %h", i, got, {1'b1, 8'd20, CW'(3)});
         end
      end
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 2);
         in_data  = 8'(23 + i);
         step();
         if (i < 4) exp = {1'b1, 8'(21 + i), (i < 2) ? CW'(3) : CW'(4 - i)};
         else       exp = {1'b0, 8'd24, CW'(0)};
         got = {out_valid, out_data, count};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL en_resume[%0d]: got {v,d,c}=%h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [WIDTH+CW:0] got;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(30 + i);
         step();
      end
      #1;
      reset = 1'b0;
      #1;
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b0, RV, CW'(0)} || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got {v,d,c}=%h rdy=%0b want %h rdy=0", got, in_ready, {1'b0, RV, CW'(0)});
      end
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b0, RV, CW'(0)}) begin
         bad++;
         $display("FAIL async_reset_release: got {v,d,c}=%h want %h", got, {1'b0, RV, CW'(0)});
      end
   endtask

`ifdef REG_PIPE_SCLR_EN
   task automatic test_sclr();
      logic [WIDTH+CW:0] got;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(40 + i);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b1, 8'd41, CW'(2)}) begin
         bad++;
         $display("FAIL sclr_setup: got {v,d,c}=%h want %h", got, {1'b1, 8'd41, CW'(2)});
      end
      sclr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL sclr_in_ready: got %0b want 0", in_ready);
      end
      step();
      sclr = 1'b0; in_valid = 1'b0;
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b0, RV, CW'(0)}) begin
         bad++;
         $display("FAIL sclr_clear: got {v,d,c}=%h want %h", got, {1'b0, RV, CW'(0)});
      end
      for (int i = 0; i < 3; i++) step();
      got = {out_valid, out_data, count};
      total++;
      if (got !== {1'b0, RV, CW'(0)}) begin
         bad++;
         $display("FAIL sclr_no_accept: got {v,d,c}=%h want %h", got, {1'b0, RV, CW'(0)});
      end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      reset = 1'b0; en = 1'b1; sclr = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_enable();
      test_async_reset();
`ifdef REG_PIPE_SCLR_EN
      test_sclr();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
